// File: rtl/exu_alu_stage.sv
// Execute-stage wrapper around an external ALU: operand register, ALU drive, 2-entry result buffer.
// Optional performance counters (perf_ops, perf_stall) are built when EXU_ALU_PERF_EN is defined.
module exu_alu_stage #(
  parameter int DATA_W   = 32,
  parameter int FUNC_W   = 4,
  parameter int FUNC_MAX = 10,
  parameter int RD_W     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_rs1,
  input  logic [DATA_W-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_b_sel,
  input  logic [FUNC_W-1:0] in_func,
  input  logic [RD_W-1:0]   in_rd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [DATA_W-1:0] alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
  output logic              out_illegal
`ifdef EXU_ALU_PERF_EN
  ,
  output logic [31:0]       perf_ops,
  output logic [31:0]       perf_stall
`endif
);

  logic              op_valid;
  logic              op_illegal;
  logic [RD_W-1:0]   op_rd;

  logic [DATA_W-1:0] buf_result  [2];
  logic [RD_W-1:0]   buf_rd      [2];
  logic              buf_wen     [2];
  logic              buf_illegal [2];
  logic [1:0]        count;
  logic              rd_ptr;
  logic              wr_ptr;

  logic              pop;
  logic              push;
  logic              push_ok;
  logic              accept;
  logic [DATA_W-1:0] push_result;
  logic              push_wen;

  // A pop on the same edge frees a slot, so a full buffer can still take a push.
  always_comb begin
    pop         = (count != 2'd0) && out_ready;
    push_ok     = (count != 2'd2) || pop;
    push        = op_valid && push_ok;
    in_ready    = !op_valid || push_ok;
    accept      = in_valid && in_ready;
    push_result = op_illegal ? '0 : alu_result;
    push_wen    = (op_rd != '0) && !op_illegal;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_valid   <= 1'b0;
      op_illegal <= 1'b0;
      op_rd      <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_func   <= '0;
    end else begin
      if (accept) begin
        op_valid   <= 1'b1;
        op_illegal <= (32'(in_func) >= FUNC_MAX);
        op_rd      <= in_rd;
        alu_a      <= in_rs1;
        alu_b      <= in_b_sel ? in_imm : in_rs2;
        alu_func   <= in_func;
      end else if (push) begin
        op_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_result[i]  <= '0;
        buf_rd[i]      <= '0;
        buf_wen[i]     <= 1'b0;
        buf_illegal[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        buf_result[wr_ptr]  <= push_result;
        buf_rd[wr_ptr]      <= op_rd;
        buf_wen[wr_ptr]     <= push_wen;
        buf_illegal[wr_ptr] <= op_illegal;
        wr_ptr              <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    out_valid   = (count != 2'd0);
    out_result  = buf_result[rd_ptr];
    out_rd      = buf_rd[rd_ptr];
    out_wen     = buf_wen[rd_ptr];
    out_illegal = buf_illegal[rd_ptr];
  end

`ifdef EXU_ALU_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (push) begin
        perf_ops <= perf_ops + 32'd1;
      end
      if (op_valid && !push_ok) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_exu_alu_stage.sv
// Scoreboard bench for exu_alu_stage with a behavioural ALU stand-in and randomized traffic.
module tb_exu_alu_stage;
  localparam int DATA_W   = 32;
  localparam int FUNC_W   = 4;
  localparam int FUNC_MAX = 10;
  localparam int RD_W     = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_rs1, in_rs2, in_imm;
  logic              in_b_sel;
  logic [FUNC_W-1:0] in_func;
  logic [RD_W-1:0]   in_rd;
  logic [DATA_W-1:0] alu_a, alu_b, alu_result;
  logic [FUNC_W-1:0] alu_func;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_result;
  logic [RD_W-1:0]   out_rd;
  logic              out_wen, out_illegal;

  exu_alu_stage #(.DATA_W(DATA_W), .FUNC_W(FUNC_W), .FUNC_MAX(FUNC_MAX), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_b_sel(in_b_sel),
    .in_func(in_func), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wen;
    logic        illegal;
  } exp_t;

  exp_t        sbq[$];
  int          vectors    = 0;
  int          miscompares = 0;
  int          occ        = 0;
  logic        have_op    = 1'b0;
  logic [31:0] last_a, last_b;
  logic [3:0]  last_f;
  logic        rand_mode  = 1'b0;
  logic        stall_prev = 1'b0;
  exp_t        held;

  // Function codes 0..9: ADD SUB AND OR XOR SLL SRL SRA SLT SLTU; anything else yields junk.
  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      4'd8:    return {31'b0, $signed(a) < $signed(b)};
      4'd9:    return {31'b0, a < b};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_result = alu_ref(alu_a, alu_b, alu_func);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timeout at %0t", name, $time);
  endtask

  // Stimulus side: record expectations on accept and track pipeline occupancy.
  always @(negedge clk) begin
    if (rst) begin
      logic acc, pp;
      exp_t e;
      acc = in_valid && in_ready;
      pp  = out_valid && out_ready;
      check("in_ready", {31'b0, in_ready}, {31'b0, (occ < 3) || pp});
      if (occ == 0) check("out_valid_empty", {31'b0, out_valid}, 32'd0);
      if (occ >= 2) check("out_valid_busy", {31'b0, out_valid}, 32'd1);
      if (have_op) begin
        check("alu_a", alu_a, last_a);
        check("alu_b", alu_b, last_b);
        check("alu_func", {28'b0, alu_func}, {28'b0, last_f});
      end
      if (acc) begin
        last_a  = in_rs1;
        last_b  = in_b_sel ? in_imm : in_rs2;
        last_f  = in_func;
        have_op = 1'b1;
        e.illegal = (int'(in_func) >= FUNC_MAX);
        e.result  = e.illegal ? 32'd0 : alu_ref(last_a, last_b, in_func);
        e.rd      = in_rd;
        e.wen     = (in_rd != 5'd0) && !e.illegal;
        sbq.push_back(e);
      end
      occ = occ + int'(acc) - int'(pp);
    end
  end

  // Output side: pop and compare whenever the head is taken; hold-stability under stall.
  always @(negedge clk) begin
    if (rst) begin
      exp_t e;
      if (stall_prev && out_valid) begin
        check("hold_result", out_result, held.result);
        check("hold_rd", {27'b0, out_rd}, {27'b0, held.rd});
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_output: got result %h rd %0d expected none", out_result, out_rd);
        end else begin
          e = sbq.pop_front();
          check("out_result", out_result, e.result);
          check("out_rd", {27'b0, out_rd}, {27'b0, e.rd});
          check("out_wen", {31'b0, out_wen}, {31'b0, e.wen});
          check("out_illegal", {31'b0, out_illegal}, {31'b0, e.illegal});
        end
      end
      stall_prev  = out_valid && !out_ready;
      held.result = out_result;
      held.rd     = out_rd;
    end else begin
      stall_prev = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_mode) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wait_accept(input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 100) begin
        fail_timeout(name);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic bsel, input logic [3:0] f, input logic [4:0] rd);
    in_valid = 1'b1;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    in_b_sel = bsel;
    in_func  = f;
    in_rd    = rd;
  endtask

  task automatic send_op(input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                         input logic bsel, input logic [3:0] f, input logic [4:0] rd);
    set_op(rs1, rs2, imm, bsel, f, rd);
    wait_accept("accept_wait");
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send_op($urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));
  endtask

  task automatic drain();
    int n = 0;
    forever begin
      @(negedge clk);
      #1;
      if (occ == 0 && sbq.size() == 0) break;
      n++;
      if (n > 100) begin
        fail_timeout("drain");
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1);
  end

  initial begin
    time t0;
    rst = 1'b0;
    out_ready = 1'b1;
    set_op(32'd5, 32'd0, 32'd7, 1'b1, 4'd0, 5'd3);
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_func", {28'b0, alu_func}, 32'd0);

    // Single ADD: accept at edge N, result visible after edge N+1.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    check("lat_early_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_valid", {31'b0, out_valid}, 32'd1);
    check("lat_result", out_result, 32'd12);
    check("lat_rd", {27'b0, out_rd}, 32'd3);
    check("lat_wen", {31'b0, out_wen}, 32'd1);
    drain();

    // Back-to-back: four ops in four cycles.
    t0 = $time;
    repeat (4) send_rand();
    check("b2b_cycles", 32'(($time - t0) / 10), 32'd4);
    drain();

    // Backpressure: fourth op must be held upstream until the buffer drains.
    out_ready = 1'b0;
    repeat (3) send_rand();
    set_op($urandom, $urandom, $urandom, 1'b0, 4'd4, 5'd9);
    repeat (3) begin
      @(negedge clk);
      check("full_in_ready", {31'b0, in_ready}, 32'd0);
      check("full_out_valid", {31'b0, out_valid}, 32'd1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    wait_accept("bp_accept");
    in_valid = 1'b0;
    drain();

    // Illegal code and rd=0.
    send_op(32'd1, 32'd2, 32'd3, 1'b0, 4'(FUNC_MAX), 5'd4);
    send_op(32'd3, 32'd5, 32'd0, 1'b0, 4'd1, 5'd0);
    drain();

    // Randomized traffic with random gaps and random downstream readiness.
    rand_mode = 1'b1;
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk); #1;
      end
      send_rand();
    end
    rand_mode = 1'b0;
    @(posedge clk); #2 out_ready = 1'b1;
    drain();

    // Mid-operation reset with a full buffer and a held op.
    out_ready = 1'b0;
    repeat (3) send_rand();
    #1;
    rst = 1'b0;
    sbq.delete();
    occ = 0;
    have_op = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_alu_a", alu_a, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    out_ready = 1'b1;
    send_op(32'h10, 32'h20, 32'd0, 1'b0, 4'd0, 5'd7);
    drain();
    check("final_queue_empty", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/exu_alu_stage.md
Name: exu_alu_stage

Overview:
- Execute-stage wrapper placed directly upstream of the ALU and consuming its result.
- Accepts decoded operations over a valid/ready handshake and registers the operands. It drives the ALU's a/b/func inputs from those registers, then captures alu_result into a 2-entry output buffer that feeds writeback over a second valid/ready handshake.
- Full throughput: one operation per cycle when downstream is ready.

Parameters:
- DATA_W, 32, operand/result width (matches ISA_WIDTH).
- FUNC_W, 4, ALU function code width (matches ALU_FUNC_WIDTH).
- FUNC_MAX, 10, number of legal function codes; codes >= FUNC_MAX are illegal.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream operation valid.
- in_ready  out  1  stage can accept an operation this cycle.
- in_rs1  in  DATA_W  operand A.
- in_rs2  in  DATA_W  register operand B.
- in_imm  in  DATA_W  immediate operand B.
- in_b_sel  in  1  1 selects in_imm as operand B, 0 selects in_rs2.
- in_func  in  FUNC_W  ALU function code.
- in_rd  in  RD_W  destination register index.
- alu_a  out  DATA_W  to ALU operand a.
- alu_b  out  DATA_W  to ALU operand b.
- alu_func  out  FUNC_W  to ALU function select.
- alu_result  in  DATA_W  combinational result from ALU.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  downstream accepts head.
- out_result  out  DATA_W  head result.
- out_rd  out  RD_W  head destination index.
- out_wen  out  1  head writes back; 0 if rd==0 or op was illegal.
- out_illegal  out  1  head op had func >= FUNC_MAX.

Behaviour:
- Reset (rst low, asynchronous):
  - op_valid, buffer count, read/write pointers and all out_* clear to 0.
  - alu_a, alu_b and alu_func registers clear to 0.
  - Reset mid-operation discards the in-flight op and all buffered entries; no partial output.
- Stage 1, operand register:
  - Accept when in_valid && in_ready.
  - On accept, latch in_rs1 -> alu_a, (in_b_sel ? in_imm : in_rs2) -> alu_b, in_func -> alu_func, plus rd and an illegal flag; set op_valid=1.
  - alu_* hold their last value when op_valid=0; they are not cleared.
- Stage 2, buffer push:
  - While op_valid=1, push {alu_result, rd, wen, illegal} into the buffer at the next edge when push_ok. That edge consumes the op.
  - push_ok = (count<2) || (out_valid && out_ready).
  - For an illegal op, push result=0, illegal=1, wen=0; the ALU output is ignored.
- Handshake:
  - in_ready = !op_valid || push_ok. This is combinational; it allows accept and push on the same edge.
- Latency:
  - Accept at edge N -> out_valid=1 after edge N+1 (buffer empty, no stall).
- Buffer:
  - 2 entries, 1-bit pointers that wrap from 1 back to 0.
  - count ranges 0..2.
  - out_* always present the head entry; out_valid = (count!=0).
  - Head contents are stable while out_valid && !out_ready.
- Simultaneous events:
  - Push with pop when count=2: pop the head, write the freed slot, count stays 2.
  - Push with pop when count=1: count stays 1.
  - Pop with no push: count decrements.
- Full:
  - count=2 with no pop: push_ok=0 and op_valid holds. in_ready=0 if op_valid.
- Empty:
  - out_valid=0; out_* hold their stale head values, which are don't-care.
- wen rule: wen = (rd != 0) && !illegal.

Optional Feature:
- Macro: EXU_ALU_PERF_EN.
- Defined:
  - Adds ports perf_ops (out, 32) and perf_stall (out, 32), both reset to 0.
  - perf_ops increments on every buffer push.
  - perf_stall increments on every cycle with op_valid && !push_ok.
  - Both wrap at 2^32.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 with in_valid=1 -> in_ready=1, out_valid=0, alu_a/alu_b/alu_func=0. Release rst -> first op accepted.
- Single ADD, rs1=5, imm=7, b_sel=1, rd=3: accept at edge N -> out_valid after N+1, out_result=12, out_rd=3, out_wen=1.
- Back-to-back: 4 ops with out_ready=1 -> one result per cycle, in order, in_ready stays 1.
- Backpressure: out_ready=0 while sending 4 ops.
  - count reaches 2, op_valid=1, in_ready=0; the 4th op is held upstream.
  - Raise out_ready -> results drain in order, none lost or duplicated.
- Illegal and rd=0:
  - func=FUNC_MAX -> out_illegal=1, out_result=0, out_wen=0.
  - Legal SUB, rs1=3, rs2=5, rd=0 -> out_result=0xFFFFFFFE, out_wen=0.
- Mid-op reset: pull rst low with count=2 and op_valid=1 -> out_valid drops immediately (asynchronous). After release, the first new op is output with no stale entries.
